// File: rtl/tx_8b10b_encoder.sv
// 8b10b transmit encoder: ALIGN comma burst after reset, then a RUN state that
// encodes accepted words with a one-cycle registered latency.
module tx_8b10b_encoder #(
   parameter int ALIGN_COUNT  = 16,
   parameter int COMMA_PERIOD = 256
) (
   input  logic       clk_div,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_k,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [9:0] data_parallel,
   output logic       rd_out,
   output logic       code_err
);

   // Handshake: a word transfers on a clk_div edge where tx_valid && tx_ready;
   // tx_ready is a function of state and period count only, never of tx_valid.

   typedef enum logic {S_ALIGN = 1'b0, S_RUN = 1'b1} state_t;

   localparam int            AW          = (ALIGN_COUNT > 1) ? $clog2(ALIGN_COUNT) : 1;
   localparam logic [AW-1:0] ALIGN_LAST  = AW'(ALIGN_COUNT - 1);
   localparam int            PW          = (COMMA_PERIOD > 1) ? $clog2(COMMA_PERIOD) : 1;
   localparam int            PLAST_I     = (COMMA_PERIOD > 0) ? COMMA_PERIOD - 1 : 0;
   localparam logic [PW-1:0] PERIOD_LAST = PW'(PLAST_I);
   localparam bit            COMMA_EN    = (COMMA_PERIOD > 0);

   state_t        r_state, w_state_nxt;
   logic [AW-1:0] r_align_cnt;
   logic [PW-1:0] r_pcnt;
   logic [9:0]    r_data;
   logic          r_rd, r_err;

   logic       w_forced, w_tx_ready, w_accept, w_k_ok, w_err_nxt, w_k;
   logic [7:0] w_byte;
   logic [5:0] w_s6_base, w_s6;
   logic [3:0] w_s4_base, w_s4;
   logic       w_flip6, w_flip4, w_rd6, w_rd_nxt, w_a7;
   logic [9:0] w_word;

   // 5b/6b code at RD-, written abcdei with 'a' as the MSB.
   function automatic logic [5:0] enc6(input logic [4:0] x);
      case (x)
         5'd0:  enc6 = 6'b100111;  5'd1:  enc6 = 6'b011101;
         5'd2:  enc6 = 6'b101101;  5'd3:  enc6 = 6'b110001;
         5'd4:  enc6 = 6'b110101;  5'd5:  enc6 = 6'b101001;
         5'd6:  enc6 = 6'b011001;  5'd7:  enc6 = 6'b111000;
         5'd8:  enc6 = 6'b111001;  5'd9:  enc6 = 6'b100101;
         5'd10: enc6 = 6'b010101;  5'd11: enc6 = 6'b110100;
         5'd12: enc6 = 6'b001101;  5'd13: enc6 = 6'b101100;
         5'd14: enc6 = 6'b011100;  5'd15: enc6 = 6'b010111;
         5'd16: enc6 = 6'b011011;  5'd17: enc6 = 6'b100011;
         5'd18: enc6 = 6'b010011;  5'd19: enc6 = 6'b110010;
         5'd20: enc6 = 6'b001011;  5'd21: enc6 = 6'b101010;
         5'd22: enc6 = 6'b011010;  5'd23: enc6 = 6'b111010;
         5'd24: enc6 = 6'b110011;  5'd25: enc6 = 6'b100110;
         5'd26: enc6 = 6'b010110;  5'd27: enc6 = 6'b110110;
         5'd28: enc6 = 6'b001110;  5'd29: enc6 = 6'b101110;
         5'd30: enc6 = 6'b011110;  default: enc6 = 6'b101011;
      endcase
   endfunction

   // 3b/4b data code at RD-, written fghj with 'f' as the MSB (primary D.x.7).
   function automatic logic [3:0] enc4(input logic [2:0] y);
      case (y)
         3'd0: enc4 = 4'b1011;  3'd1: enc4 = 4'b1001;
         3'd2: enc4 = 4'b0101;  3'd3: enc4 = 4'b1100;
         3'd4: enc4 = 4'b1101;  3'd5: enc4 = 4'b1010;
         3'd6: enc4 = 4'b0110;  default: enc4 = 4'b1110;
      endcase
   endfunction

   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         r_state     <= S_ALIGN;
         r_align_cnt <= '0;
         r_pcnt      <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_ALIGN) begin
            r_align_cnt <= (r_align_cnt == ALIGN_LAST) ? '0 : r_align_cnt + 1'b1;
            r_pcnt      <= '0;
         end else begin
            r_align_cnt <= '0;
            r_pcnt      <= (!COMMA_EN || r_pcnt == PERIOD_LAST) ? '0 : r_pcnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == S_ALIGN && r_align_cnt == ALIGN_LAST)
         w_state_nxt = S_RUN;
   end

   // Anything not accepted (align, idle, forced comma, bad K) becomes K28.5.
   always_comb begin
      w_forced   = COMMA_EN && (r_pcnt == PERIOD_LAST);
      w_tx_ready = (r_state == S_RUN) && !w_forced;
      w_accept   = tx_valid && w_tx_ready;
      w_k_ok     = (tx_data[4:0] == 5'd28) ||
                   ((tx_data[7:5] == 3'd7) &&
                    (tx_data[4:0] == 5'd23 || tx_data[4:0] == 5'd27 ||
                     tx_data[4:0] == 5'd29 || tx_data[4:0] == 5'd30));
      w_err_nxt  = 1'b0;
      w_byte     = 8'hBC;
      w_k        = 1'b1;
      if (w_accept) begin
         if (tx_k && !w_k_ok) begin
            w_err_nxt = 1'b1;
         end else begin
            w_byte = tx_data;
            w_k    = tx_k;
         end
      end
   end

   always_comb begin
      w_s6_base = (w_k && w_byte[4:0] == 5'd28) ? 6'b001111 : enc6(w_byte[4:0]);
      w_flip6   = ($countones(w_s6_base) != 3);
      w_s6      = (r_rd && (w_flip6 || w_byte[4:0] == 5'd7)) ? ~w_s6_base : w_s6_base;
      w_rd6     = r_rd ^ w_flip6;
      w_a7      = (w_byte[7:5] == 3'd7) &&
                  (w_k ||
                   (!w_rd6 && (w_byte[4:0] == 5'd17 || w_byte[4:0] == 5'd18 ||
                               w_byte[4:0] == 5'd20)) ||
                   ( w_rd6 && (w_byte[4:0] == 5'd11 || w_byte[4:0] == 5'd13 ||
                               w_byte[4:0] == 5'd14)));
      w_s4_base = w_a7 ? 4'b0111 : enc4(w_byte[7:5]);
      w_flip4   = ($countones(w_s4_base) != 2);
      // K.x.1/2/5/6 use the inverted neutral form at RD- so commas stay unique.
      if (w_k && (w_byte[7:5] == 3'd1 || w_byte[7:5] == 3'd2 ||
                  w_byte[7:5] == 3'd5 || w_byte[7:5] == 3'd6))
         w_s4 = w_rd6 ? w_s4_base : ~w_s4_base;
      else
         w_s4 = (w_rd6 && (w_flip4 || w_byte[7:5] == 3'd3)) ? ~w_s4_base : w_s4_base;
      w_rd_nxt = w_rd6 ^ w_flip4;
      w_word   = {w_s4[0], w_s4[1], w_s4[2], w_s4[3],
                  w_s6[0], w_s6[1], w_s6[2], w_s6[3], w_s6[4], w_s6[5]};
   end

   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         r_data <= 10'h000;
         r_rd   <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_data <= w_word;
         r_rd   <= w_rd_nxt;
         r_err  <= w_err_nxt;
      end
   end

   assign tx_ready      = w_tx_ready;
   assign data_parallel = r_data;
   assign rd_out        = r_rd;
   assign code_err      = r_err;

endmodule

// File: tb/tb_tx_8b10b_encoder.sv
// Directed bench for tx_8b10b_encoder (ALIGN_COUNT=4, COMMA_PERIOD=8) with
// hand-computed 10-bit words and running disparity.
module tb_tx_8b10b_encoder;

   logic       clk_div = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_k;
   logic       tx_valid;
   logic       tx_ready;
   logic [9:0] data_parallel;
   logic       rd_out;
   logic       code_err;

   int n_total = 0;
   int n_pass  = 0;

   tx_8b10b_encoder #(.ALIGN_COUNT(4), .COMMA_PERIOD(8)) dut (
      .clk_div       (clk_div),
      .rst           (rst),
      .tx_data       (tx_data),
      .tx_k          (tx_k),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .data_parallel (data_parallel),
      .rd_out        (rd_out),
      .code_err      (code_err)
   );

   always #5 clk_div = ~clk_div;

   task automatic tick();
      @(posedge clk_div);
      #1;
   endtask

   task automatic drive(input logic v, input logic k, input logic [7:0] d);
      tx_valid = v;
      tx_k     = k;
      tx_data  = d;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_total++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
   endtask

   task automatic chk_out(input string tag, input logic [9:0] w, input logic rd, input logic err);
      chk({tag, "_word"}, {6'd0, data_parallel}, {6'd0, w});
      chk({tag, "_rd"},   {15'd0, rd_out},       {15'd0, rd});
      chk({tag, "_err"},  {15'd0, code_err},     {15'd0, err});
   endtask

   // Stream D9.5..D22.5 across two forced-comma slots.
   logic [9:0] exp_word [16] = '{10'h169, 10'h16A, 10'h14B, 10'h16C, 10'h14D, 10'h14E,
                                 10'h17C, 10'h145, 10'h176, 10'h171, 10'h172, 10'h153,
                                 10'h174, 10'h155, 10'h283, 10'h156};
   logic       exp_rd   [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic       exp_rdy  [16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      logic [7:0] byte_v;
      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00);
      #2;
      chk_out("reset", 10'h000, 1'b0, 1'b0);
      chk("reset_ready", {15'd0, tx_ready}, 16'd0);

      @(negedge clk_div);
      rst = 1'b0;
      tick(); chk_out("align0", 10'h17C, 1'b1, 1'b0); chk("align0_rdy", {15'd0, tx_ready}, 16'd0);
      tick(); chk_out("align1", 10'h283, 1'b0, 1'b0); chk("align1_rdy", {15'd0, tx_ready}, 16'd0);
      tick(); chk_out("align2", 10'h17C, 1'b1, 1'b0); chk("align2_rdy", {15'd0, tx_ready}, 16'd0);
      tick(); chk_out("align3", 10'h283, 1'b0, 1'b0); chk("run_rdy", {15'd0, tx_ready}, 16'd1);
      tick(); chk_out("idle0", 10'h17C, 1'b1, 1'b0);
      tick(); chk_out("idle1", 10'h283, 1'b0, 1'b0);

      drive(1'b1, 1'b0, 8'hB5); tick(); chk_out("d21_5", 10'h155, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 8'h00); tick(); chk_out("d0_0a", 10'h0B9, 1'b0, 1'b0);
      tick();                           chk_out("d0_0b", 10'h0B9, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 8'hBC); tick(); chk_out("k28_5", 10'h17C, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 8'h00); tick(); chk_out("bad_k", 10'h283, 1'b0, 1'b1);
      chk("forced_rdy", {15'd0, tx_ready}, 16'd0);
      drive(1'b0, 1'b0, 8'h00); tick(); chk_out("forced", 10'h17C, 1'b1, 1'b0);
      chk("after_forced_rdy", {15'd0, tx_ready}, 16'd1);
      tick(); chk_out("idle2", 10'h283, 1'b0, 1'b0);

      byte_v = 8'hA9;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, byte_v);
         chk($sformatf("stream%0d_rdy", i), {15'd0, tx_ready}, {15'd0, exp_rdy[i]});
         tick();
         chk_out($sformatf("stream%0d", i), exp_word[i], exp_rd[i], 1'b0);
         if (exp_rdy[i]) byte_v = byte_v + 8'd1;
      end

      drive(1'b0, 1'b0, 8'h00); tick(); chk_out("idle3", 10'h17C, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 8'hEB); tick(); chk_out("d11_a7", 10'h04B, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 8'hF1); tick(); chk_out("d17_a7", 10'h3B1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 8'hF7); tick(); chk_out("k23_7",  10'h3A8, 1'b1, 1'b0);

      // In-flight word then asynchronous reset between edges.
      drive(1'b1, 1'b0, 8'h55);
      #2;
      rst = 1'b1;
      #1;
      chk_out("async_rst", 10'h000, 1'b0, 1'b0);
      chk("async_rst_rdy", {15'd0, tx_ready}, 16'd0);
      tick(); chk_out("held_rst", 10'h000, 1'b0, 1'b0);
      @(negedge clk_div);
      rst = 1'b0;
      drive(1'b0, 1'b0, 8'h00);
      tick(); chk_out("realign0", 10'h17C, 1'b1, 1'b0); chk("realign0_rdy", {15'd0, tx_ready}, 16'd0);
      tick(); chk_out("realign1", 10'h283, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
